// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// 640x480@60 Hz VGA raster generator. Produces the pixel/line counters used
// by the display-region decoders, the active-low connector sync pulses and a
// video-valid qualifier. Sync and valid can be delayed by PIPE_DLY pixel
// slots so they line up with downstream registered region flags.
//
// Ports:
//   clk        in   system clock (25 MHz when pix_en is tied high)
//   rst        in   synchronous active-high reset
//   pix_en     in   pixel-slot enable; all state advances only when high
//   h_cnt      out  horizontal position, 0..H_TOT-1
//   v_cnt      out  vertical position, 0..V_TOT-1
//   hsync      out  active-low horizontal sync, delayed by PIPE_DLY slots
//   vsync      out  active-low vertical sync, delayed by PIPE_DLY slots
//   valid      out  pixel in visible area, delayed by PIPE_DLY slots
//   line_tick  out  pulse on the last pixel of each line (undelayed)
//   frame_tick out  pulse on the last pixel of each frame (undelayed)
//
// PIPE_DLY legal range is 0..3.

module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

  // Delay-stage contents are {hs, vs, vld}; idle is sync high, not valid.
  localparam logic [2:0] IDLE = 3'b110;

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  logic       h_last, v_last;
  logic       hs_raw, vs_raw, vld_raw;
  logic [2:0] raw;

  assign h_last = (h_cnt_reg == H_LAST);
  assign v_last = (v_cnt_reg == V_LAST);

  // Counter next-state: h wraps at the end of the line and carries into v,
  // v wraps only when h wraps on the last line.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_en) begin
      if (h_last) begin
        h_cnt_next = '0;
        if (v_last) begin
          v_cnt_next = '0;
        end else begin
          v_cnt_next = v_cnt_reg + 10'd1;
        end
      end else begin
        h_cnt_next = h_cnt_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  assign h_cnt = h_cnt_reg;
  assign v_cnt = v_cnt_reg;

  // Raw decode of the current counter position.
  assign hs_raw  = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
  assign vs_raw  = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));
  assign vld_raw = (h_cnt_reg < H_VIS_END) && (v_cnt_reg < V_VIS_END);
  assign raw     = {hs_raw, vs_raw, vld_raw};

  // Ticks are combinational so they coincide with the counter value they
  // describe, and they vanish in slots where pix_en is low.
  assign line_tick  = pix_en && h_last;
  assign frame_tick = line_tick && v_last;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hsync = hs_raw;
      assign vsync = vs_raw;
      assign valid = vld_raw;
    end else begin : g_dly
      // One register per delay stage; each stage shifts only on enabled
      // slots so the delay is measured in pixel slots, not clocks.
      for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : g_stage
        logic [2:0] q_reg;
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) begin
            if (rst) begin
              q_reg <= IDLE;
            end else if (pix_en) begin
              q_reg <= raw;
            end
          end
        end else begin : g_next
          always_ff @(posedge clk) begin
            if (rst) begin
              q_reg <= IDLE;
            end else if (pix_en) begin
              q_reg <= g_stage[gi-1].q_reg;
            end
          end
        end
      end
      assign {hsync, vsync, valid} = g_stage[PIPE_DLY-1].q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Four instances share clk/rst/pix_en:
//   u_a  full-size raster, delay 1
//   u_b  full-size raster, delay 2
//   u_c  small raster (16x11 slots), delay 3 -- used for whole-frame checks
//   u_d  small raster, delay 0
// The reference model counts enabled slots since the last reset and derives
// every output from that count with modular arithmetic.

module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vld;
    logic       lt;
    logic       ft;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v, d_h, d_v;
  logic a_hs, a_vs, a_vld, a_lt, a_ft;
  logic b_hs, b_vs, b_vld, b_lt, b_ft;
  logic c_hs, c_vs, c_vld, c_lt, c_ft;
  logic d_hs, d_vs, d_vld, d_lt, d_ft;

  vga_timing_gen #(.PIPE_DLY(1)) u_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(a_h), .v_cnt(a_v),
    .hsync(a_hs), .vsync(a_vs), .valid(a_vld), .line_tick(a_lt), .frame_tick(a_ft));

  vga_timing_gen #(.PIPE_DLY(2)) u_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(b_h), .v_cnt(b_v),
    .hsync(b_hs), .vsync(b_vs), .valid(b_vld), .line_tick(b_lt), .frame_tick(b_ft));

  vga_timing_gen #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(3)) u_c (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(c_h), .v_cnt(c_v),
    .hsync(c_hs), .vsync(c_vs), .valid(c_vld), .line_tick(c_lt), .frame_tick(c_ft));

  vga_timing_gen #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(0)) u_d (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(d_h), .v_cnt(d_v),
    .hsync(d_hs), .vsync(d_vs), .valid(d_vld), .line_tick(d_lt), .frame_tick(d_ft));

  obs_t a_obs, b_obs, c_obs, d_obs;
  assign a_obs = {a_h, a_v, a_hs, a_vs, a_vld, a_lt, a_ft};
  assign b_obs = {b_h, b_v, b_hs, b_vs, b_vld, b_lt, b_ft};
  assign c_obs = {c_h, c_v, c_hs, c_vs, c_vld, c_lt, c_ft};
  assign d_obs = {d_h, d_v, d_hs, d_vs, d_vld, d_lt, d_ft};

  int ncomp = 0;
  int nmis  = 0;
  int n     = 0;      // enabled slots since the last reset edge
  logic armed = 1'b0; // set once a reset edge has defined the DUT state

  always @(posedge clk) begin
    if (rst) begin
      n     <= 0;
      armed <= 1'b1;
    end else if (pix_en) begin
      n <= n + 1;
    end
  end

  // Expected outputs after n enabled slots: counters are the slot index
  // folded onto the raster; delayed outputs decode slot n-d, or idle.
  function automatic obs_t model(input int cnt, hv, hf, hsw, hb, vv, vf, vsw, vb, d,
                                 input logic pe);
    int ht, vt, m, hm, vm;
    obs_t o;
    ht   = hv + hf + hsw + hb;
    vt   = vv + vf + vsw + vb;
    o.h  = 10'(cnt % ht);
    o.v  = 10'((cnt / ht) % vt);
    o.lt = pe && ((cnt % ht) == ht - 1);
    o.ft = o.lt && (((cnt / ht) % vt) == vt - 1);
    if (cnt < d) begin
      o.hs  = 1'b1;
      o.vs  = 1'b1;
      o.vld = 1'b0;
    end else begin
      m     = cnt - d;
      hm    = m % ht;
      vm    = (m / ht) % vt;
      o.hs  = !((hm >= hv + hf) && (hm < hv + hf + hsw));
      o.vs  = !((vm >= vv + vf) && (vm < vv + vf + vsw));
      o.vld = (hm < hv) && (vm < vv);
    end
    return o;
  endfunction

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    ncomp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s slot=%0d: got h=%0d v=%0d hs=%b vs=%b vld=%b lt=%b ft=%b, expected h=%0d v=%0d hs=%b vs=%b vld=%b lt=%b ft=%b",
               name, n, act.h, act.v, act.hs, act.vs, act.vld, act.lt, act.ft,
               exp.h, exp.v, exp.hs, exp.vs, exp.vld, exp.lt, exp.ft);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ncomp++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (armed) begin
      cmp("u_a", a_obs, model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1, pix_en));
      cmp("u_b", b_obs, model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2, pix_en));
      cmp("u_c", c_obs, model(n, 8, 2, 3, 3, 6, 1, 2, 2, 3, pix_en));
      cmp("u_d", d_obs, model(n, 8, 2, 3, 3, 6, 1, 2, 2, 0, pix_en));
    end
  end

  task automatic step(input logic r, input logic pe);
    @(posedge clk);
    #1;
    rst    = r;
    pix_en = pe;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", ncomp, nmis);
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt, vld_cnt, vs_low, hs_low, ft_cnt, last_ft, lt_cnt, last_lt, lt_period;

    // Reset, then the first two slots after release.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("rel0_h", int'(a_h), 0);
    chk("rel0_v", int'(a_v), 0);
    chk("rel0_valid", int'(a_vld), 0);
    chk("rel0_hsync", int'(a_hs), 1);
    chk("rel0_vsync", int'(a_vs), 1);
    chk("rel0_d_valid", int'(d_vld), 1);
    step(1'b0, 1'b1);
    chk("rel1_h", int'(a_h), 1);
    chk("rel1_valid", int'(a_vld), 1);
    $display("phase reset/release done, slot=%0d", n);

    // Free-run to (799,5), watching hsync placement on the delay-2 copy.
    low_cnt = 0;
    for (int i = 0; i < 10000 && n != 4799; i++) begin
      step(1'b0, 1'b1);
      if (n >= 2 && n < 802 && !b_hs) low_cnt++;
      case (n)
        656: chk("b_h_at_656", int'(b_h), 656);
        657: chk("b_hsync_657", int'(b_hs), 1);
        658: chk("b_hsync_658", int'(b_hs), 0);
        753: chk("b_hsync_753", int'(b_hs), 0);
        754: chk("b_hsync_754", int'(b_hs), 1);
        default: ;
      endcase
    end
    chk("reach_799_5", n, 4799);
    chk("b_hsync_low_width", low_cnt, 96);
    chk("wrap_pre_h", int'(a_h), 799);
    chk("wrap_pre_v", int'(a_v), 5);
    chk("wrap_pre_lt", int'(a_lt), 1);
    step(1'b0, 1'b1);
    chk("wrap_post_h", int'(a_h), 0);
    chk("wrap_post_v", int'(a_v), 6);
    chk("wrap_post_lt", int'(a_lt), 0);
    chk("wrap_post_ft", int'(a_ft), 0);
    $display("phase line wrap done, slot=%0d", n);

    // Random enables with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 400) == 0, ($urandom % 2) == 1);
    end
    $display("phase random done, slot=%0d", n);

    // 1-in-4 enable: two full lines in 6400 clocks.
    lt_cnt  = 0;
    last_lt = -1;
    lt_period = 3200;
    for (int i = 0; i < 6400; i++) begin
      step(1'b0, (i % 4) == 3);
      if (a_lt) begin
        lt_cnt++;
        if (last_lt >= 0) lt_period = i - last_lt;
        last_lt = i;
      end
    end
    chk("quarter_rate_ticks", lt_cnt, 2);
    chk("quarter_rate_line_clks", lt_period, 3200);
    $display("phase quarter-rate done, slot=%0d", n);

    // Whole small frames on u_c (176 slots/frame).
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("c_rst_h", int'(c_h), 0);
    vld_cnt = 0; vs_low = 0; hs_low = 0; ft_cnt = 0; last_ft = -1;
    for (int i = 0; i < 1000 && n != 444; i++) begin
      step(1'b0, 1'b1);
      if (n >= 10 && n < 186) begin
        if (c_vld) vld_cnt++;
        if (!c_vs) vs_low++;
        if (!c_hs) hs_low++;
        if (c_ft) ft_cnt++;
      end
      if (c_ft) begin
        if (last_ft >= 0) chk("c_frame_period", n - last_ft, 176);
        last_ft = n;
      end
      if (n == 175) chk("c_ft_at_last", int'(c_ft), 1);
      if (n == 176) begin
        chk("c_after_frame_h", int'(c_h), 0);
        chk("c_after_frame_v", int'(c_v), 0);
      end
    end
    chk("c_valid_per_frame", vld_cnt, 48);
    chk("c_vsync_low_per_frame", vs_low, 32);
    chk("c_hsync_low_per_frame", hs_low, 33);
    chk("c_ticks_per_frame", ft_cnt, 1);
    $display("phase small frames done, slot=%0d", n);

    // Reset mid-frame at (12,5) of the small raster.
    chk("c_premid_h", int'(c_h), 12);
    chk("c_premid_v", int'(c_v), 5);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("mid_rst_h", int'(c_h), 0);
    chk("mid_rst_v", int'(c_v), 0);
    chk("mid_rst_valid", int'(c_vld), 0);
    chk("mid_rst_hsync", int'(c_hs), 1);
    chk("mid_rst_vsync", int'(c_vs), 1);
    chk("mid_rst_a_valid", int'(a_vld), 0);
    chk("mid_rst_ticks", int'({c_lt, c_ft, a_lt, a_ft}), 0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    chk("resume_c_h", int'(c_h), 8);
    chk("resume_c_v", int'(c_v), 2);
    $display("phase mid-frame reset done, slot=%0d", n);

    $display("== %0d vectors applied, %0d miscompares ==", ncomp, nmis);
    $finish;
  end

endmodule
